// File: rtl/sound_request_arbiter.sv
// ----------------------------------------------------------------------------
// sound_request_arbiter
// Front-end scheduler for the game sound player. One-cycle game-event request
// pulses are collected as per-type pending bits. The block grants them one at
// a time by fixed priority (victory > error > start > drop) and drives the
// player's sound_type / snd_start_n inputs.
//
// The player has no busy output, so every playback is timed here:
//   ARM   -> PULSE -> PLAY -> GAP
// sound_type is held stable from ARM until the sound finishes. It only changes
// again on the next grant.
// ----------------------------------------------------------------------------
module sound_request_arbiter #(
    parameter logic [31:0] DUR_SHORT  = 32'd50_000_000 / 32'd25,
    parameter logic [31:0] DUR_LONG   = 32'd50_000_000 / 32'd10,
    parameter logic [31:0] PULSE_LEN  = 32'd4,
    parameter logic [31:0] GUARD      = 32'd8,
    parameter logic [31:0] GAP_CYCLES = 32'd500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_start,
    input  logic       req_drop,
    input  logic       req_error,
    input  logic       req_victory,
    input  logic       mute,
    output logic [1:0] sound_type,
    output logic       snd_start_n,
    output logic       busy,
    output logic       grant,
    output logic [3:0] pending
);

    // Sound type codes as understood by the player.
    localparam logic [1:0] T_START   = 2'b00;
    localparam logic [1:0] T_DROP    = 2'b01;
    localparam logic [1:0] T_ERROR   = 2'b10;
    localparam logic [1:0] T_VICTORY = 2'b11;

    // Pending-vector bit positions: {victory, error, start, drop}.
    localparam int unsigned B_DROP    = 0;
    localparam int unsigned B_START   = 1;
    localparam int unsigned B_ERROR   = 2;
    localparam int unsigned B_VICTORY = 3;

    // Playback lengths in clock cycles. These are the note count times the
    // per-note duration. They are evaluated in 32 bits and fit without wrap
    // at the default clock-derived durations.
    localparam logic [31:0] PLAY_START   = 32'd4  * (DUR_LONG  + 32'd1);
    localparam logic [31:0] PLAY_DROP    = 32'd2  * (DUR_SHORT + 32'd1);
    localparam logic [31:0] PLAY_ERROR   = 32'd2  * (DUR_LONG  + 32'd1);
    localparam logic [31:0] PLAY_VICTORY = 32'd13 * (DUR_LONG  + 32'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PULSE = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Counter preload on PULSE->PLAY. GUARD adds margin for the player's
    // input synchroniser and its entry latency, so the next sound can never
    // start while this one is still audible.
    function automatic logic [31:0] play_preload(input logic [1:0] t);
        logic [31:0] len;
        case (t)
            T_START:   len = PLAY_START;
            T_DROP:    len = PLAY_DROP;
            T_ERROR:   len = PLAY_ERROR;
            T_VICTORY: len = PLAY_VICTORY;
            default:   len = PLAY_START;
        endcase
        return len + GUARD - 32'd1;
    endfunction

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [3:0]  pending_q;
    logic [3:0]  pending_d;
    logic [1:0]  sound_type_q;
    logic        snd_start_n_q;
    logic        busy_q;
    logic        grant_q;

    logic [3:0]  req_vec_s;
    logic [1:0]  win_type_s;
    logic [3:0]  win_mask_s;
    logic        take_s;

    assign req_vec_s = {req_victory, req_error, req_start, req_drop};

    // A grant is taken only from IDLE, with work queued and the block unmuted.
    assign take_s = (state_q == S_IDLE) && (pending_q != 4'b0000) && !mute;

    // Fixed-priority winner selection over the pending set.
    always_comb begin
        win_type_s = T_START;
        win_mask_s = 4'b0000;
        if (pending_q[B_VICTORY]) begin
            win_type_s = T_VICTORY;
            win_mask_s = 4'b1000;
        end else if (pending_q[B_ERROR]) begin
            win_type_s = T_ERROR;
            win_mask_s = 4'b0100;
        end else if (pending_q[B_START]) begin
            win_type_s = T_START;
            win_mask_s = 4'b0010;
        end else if (pending_q[B_DROP]) begin
            win_type_s = T_DROP;
            win_mask_s = 4'b0001;
        end else begin
            win_type_s = T_START;
            win_mask_s = 4'b0000;
        end
    end

    // Pending-set update. Mute wipes everything. A new request is ORed in
    // after the grant-clear, so a re-request on the grant cycle survives.
    always_comb begin
        pending_d = pending_q;
        if (mute) begin
            pending_d = 4'b0000;
        end else if (take_s) begin
            pending_d = (pending_q & ~win_mask_s) | req_vec_s;
        end else begin
            pending_d = pending_q | req_vec_s;
        end
    end

    // Sequencer: pending register, playback FSM, timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 32'd0;
            pending_q     <= 4'b0000;
            sound_type_q  <= T_START;
            snd_start_n_q <= 1'b1;
            busy_q        <= 1'b0;
            grant_q       <= 1'b0;
        end else begin
            pending_q <= pending_d;
            grant_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    snd_start_n_q <= 1'b1;
                    if (take_s) begin
                        state_q      <= S_ARM;
                        sound_type_q <= win_type_s;
                        grant_q      <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                // sound_type settles for one cycle before the start edge.
                S_ARM: begin
                    state_q       <= S_PULSE;
                    cnt_q         <= PULSE_LEN - 32'd1;
                    snd_start_n_q <= 1'b0;
                end
                S_PULSE: begin
                    if (cnt_q == 32'd0) begin
                        state_q       <= S_PLAY;
                        cnt_q         <= play_preload(sound_type_q);
                        snd_start_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_PLAY: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= S_GAP;
                        cnt_q   <= GAP_CYCLES - 32'd1;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    cnt_q         <= 32'd0;
                    snd_start_n_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign sound_type  = sound_type_q;
    assign snd_start_n = snd_start_n_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_sound_request_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for sound_request_arbiter, using short timing parameters.
// The stimulus pushes one expected grant record per sound it intends to cause.
// The monitor pops a record on every grant pulse and then measures the low
// time of snd_start_n, the busy duration and sound_type stability.
// ----------------------------------------------------------------------------
module tb_sound_request_arbiter;

    localparam logic [31:0] DS = 32'd3;
    localparam logic [31:0] DL = 32'd7;
    localparam logic [31:0] PL = 32'd2;
    localparam logic [31:0] GD = 32'd4;
    localparam logic [31:0] GP = 32'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_start, req_drop, req_error, req_victory, mute;
    logic [1:0] sound_type;
    logic       snd_start_n, busy, grant;
    logic [3:0] pending;

    sound_request_arbiter #(
        .DUR_SHORT(DS), .DUR_LONG(DL), .PULSE_LEN(PL), .GUARD(GD), .GAP_CYCLES(GP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_start(req_start), .req_drop(req_drop), .req_error(req_error),
        .req_victory(req_victory), .mute(mute),
        .sound_type(sound_type), .snd_start_n(snd_start_n), .busy(busy),
        .grant(grant), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] t;
        int         low;
        int         blen;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   active   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected busy length, from hand-computed play lengths with these params.
    // Play lengths: START 4*8=32, DROP 2*4=8, ERROR 2*8=16, VICTORY 13*8=104.
    task automatic push(input logic [1:0] t);
        exp_t e;
        int   play;
        case (t)
            2'b00:   play = 32;
            2'b01:   play = 8;
            2'b10:   play = 16;
            default: play = 104;
        endcase
        e.t    = t;
        e.low  = 2;
        e.blen = 1 + 2 + play + 4 + 5;
        sb_q.push_back(e);
    endtask

    // Drive one request pulse; called and returns at posedge+#1.
    task automatic pulse(input logic [3:0] v);
        {req_victory, req_error, req_start, req_drop} = v;
        @(posedge clk); #1;
        {req_victory, req_error, req_start, req_drop} = 4'b0000;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(sb_q.size() == 0 && !active && !busy && pending == 4'b0000) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_timeout", (k >= 2000) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Monitor: pop on grant, then measure the sound until busy drops.
    initial begin : monitor
        exp_t cur;
        int   bcnt, lcnt;
        bit   unstable;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (grant) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_grant", {30'd0, sound_type}, 32'hFFFF_FFFF);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("grant_type", {30'd0, sound_type}, {30'd0, cur.t});
                        active   = 1'b1;
                        bcnt     = 0;
                        lcnt     = 0;
                        unstable = 1'b0;
                    end
                end
                if (active) begin
                    if (busy) begin
                        bcnt++;
                        if (!snd_start_n) lcnt++;
                        if (sound_type !== cur.t) unstable = 1'b1;
                    end else begin
                        chk("busy_len", bcnt, cur.blen);
                        chk("start_low_len", lcnt, cur.low);
                        chk("type_stable", {31'd0, unstable}, 32'd0);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; mute = 1'b0;
        {req_victory, req_error, req_start, req_drop} = 4'b0000;
        cyc(3);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_start_n", snd_start_n, 1'b1);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_type", sound_type, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2);

        // 1: single DROP, latency and timing.
        push(2'b01);
        pulse(4'b0001);
        @(negedge clk);
        chk("t1_pending", pending, 4'b0001);
        chk("t1_busy_early", busy, 1'b0);
        @(negedge clk);
        chk("t1_busy", busy, 1'b1);
        chk("t1_grant", grant, 1'b1);
        chk("t1_type", sound_type, 2'b01);
        chk("t1_arm_start_n", snd_start_n, 1'b1);
        @(negedge clk);
        chk("t1_pulse_start_n", snd_start_n, 1'b0);
        @(posedge clk); #1;
        wait_idle();
        chk("t1_type_hold", sound_type, 2'b01);

        // 4: mute discards a request.
        mute = 1'b1;
        pulse(4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_pending", pending, 4'b0000);
            chk("t4_busy", busy, 1'b0);
            chk("t4_start_n", snd_start_n, 1'b1);
        end
        @(posedge clk); #1;
        mute = 1'b0;
        cyc(3);
        chk("t4_after_busy", busy, 1'b0);

        // 2: simultaneous DROP + VICTORY -> VICTORY first.
        push(2'b11);
        push(2'b01);
        pulse(4'b1001);
        wait_idle();

        // 3: requests during VICTORY PLAY coalesce.
        push(2'b11);
        push(2'b10);
        push(2'b01);
        pulse(4'b1000);
        cyc(8);
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0100);
        pulse(4'b0001);
        @(negedge clk);
        chk("t3_pending", pending, 4'b0101);
        chk("t3_busy", busy, 1'b1);
        @(posedge clk); #1;
        wait_idle();

        // 6: START re-requested on its own grant cycle plays twice.
        push(2'b00);
        push(2'b00);
        req_start = 1'b1;
        cyc(1);
        cyc(1);
        req_start = 1'b0;
        @(negedge clk);
        chk("t6_grant", grant, 1'b1);
        chk("t6_pending", pending, 4'b0010);
        @(posedge clk); #1;
        wait_idle();

        // 5: reset during PLAY aborts at once.
        push(2'b10);
        pulse(4'b0100);
        cyc(8);
        pulse(4'b0001);
        rst = 1'b1;
        cyc(1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_start_n", snd_start_n, 1'b1);
        chk("t5_pending", pending, 4'b0000);
        chk("t5_type", sound_type, 2'b00);
        chk("t5_grant", grant, 1'b0);
        rst = 1'b0;
        cyc(4);
        chk("t5_stays_idle", busy, 1'b0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
